// File: rtl/sobel_window_ctrl_pkg.sv
// Shared pixel width, FSM state encoding and 3x3 window tap indices for the
// Sobel window controller.
package sobel_window_ctrl_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;

  typedef logic [PIXEL_WIDTH_OUT-1:0] pix_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Row-major window taps: row 0 is two lines up, column 2 is the newest pixel.
  localparam int WIN_R0C0 = 0;
  localparam int WIN_R0C1 = 1;
  localparam int WIN_R0C2 = 2;
  localparam int WIN_R1C0 = 3;
  localparam int WIN_R1C1 = 4;
  localparam int WIN_R1C2 = 5;
  localparam int WIN_R2C0 = 6;
  localparam int WIN_R2C1 = 7;
  localparam int WIN_R2C2 = 8;

endpackage

// File: rtl/sobel_window_ctrl_line_buffer.sv
// One line of pixel storage: combinational read and registered write at the
// same address, so a read in the write cycle returns the previous line.
module sobel_line_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// 3x3 window generator for a streaming Sobel filter. Defining
// SOBEL_STALL_CNT_EN adds a saturating downstream-stall counter (stall_cnt_o).
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] pixel_i,
  input  logic                       pixel_valid_i,
  input  logic                       sof_i,
  output logic                       pixel_ready_o,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o0,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o1,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o2,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o3,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o4,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o5,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o6,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o7,
  output logic [PIXEL_WIDTH_OUT-1:0] win_o8,
  output logic                       win_valid_o,
  input  logic                       win_ready_i,
`ifdef SOBEL_STALL_CNT_EN
  output logic [15:0]                stall_cnt_o,
`endif
  output logic                       frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, cur_col;
  logic [RW-1:0]  row_q, row_d, cur_row;
  logic           accept, proc, last_px, new_win;
  pix_t           lb1_rd, lb2_rd;
  pix_t [2:0]     col_in;
  pix_t [2:0][1:0] tap_q;
  pix_t [8:0]     win_q;
  logic           win_valid_q, frame_done_q;

  assign pixel_ready_o = !win_valid_q || win_ready_i;
  assign accept        = pixel_valid_i && pixel_ready_o;
  // An sof beat is always pixel (0,0); other beats only count inside a frame.
  assign proc          = accept && (sof_i || state_q == ACTIVE);
  assign cur_col       = sof_i ? '0 : col_q;
  assign cur_row       = sof_i ? '0 : row_q;
  assign last_px       = (cur_row == RW'(IMG_HEIGHT-1)) && (cur_col == CW'(IMG_WIDTH-1));
  assign new_win       = proc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (proc) begin
      if (last_px) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = ACTIVE;
        if (cur_col == CW'(IMG_WIDTH-1)) begin
          col_d = '0;
          row_d = cur_row + 1'b1;
        end else begin
          col_d = cur_col + 1'b1;
          row_d = cur_row;
        end
      end
    end
  end

  // lb1 holds row-1; its old contents cascade into lb2 (row-2) on each write.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_WIDTH_OUT), .AW(CW)) u_lb1 (
    .clk_i(clk_i), .we_i(proc), .addr_i(cur_col), .wdata_i(pixel_i), .rdata_o(lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_WIDTH_OUT), .AW(CW)) u_lb2 (
    .clk_i(clk_i), .we_i(proc), .addr_i(cur_col), .wdata_i(lb1_rd), .rdata_o(lb2_rd)
  );

  assign col_in = {pixel_i, lb1_rd, lb2_rd};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= proc && last_px;
      if (proc) begin
        for (int k = 0; k < 3; k++) begin
          tap_q[k][1] <= tap_q[k][0];
          tap_q[k][0] <= col_in[k];
        end
      end
      // Taps refill at c=0,1 of every line, so windows never straddle a wrap.
      if (new_win) begin
        for (int k = 0; k < 3; k++) begin
          win_q[3*k+0] <= tap_q[k][1];
          win_q[3*k+1] <= tap_q[k][0];
          win_q[3*k+2] <= col_in[k];
        end
        win_valid_q <= 1'b1;
      end else if (win_ready_i) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef SOBEL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                        stall_q <= '0;
    else if (accept && sof_i)                                         stall_q <= '0;
    else if (win_valid_q && !win_ready_i && stall_q != 16'hFFFF)      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;
  assign win_o0 = win_q[WIN_R0C0];
  assign win_o1 = win_q[WIN_R0C1];
  assign win_o2 = win_q[WIN_R0C2];
  assign win_o3 = win_q[WIN_R1C0];
  assign win_o4 = win_q[WIN_R1C1];
  assign win_o5 = win_q[WIN_R1C2];
  assign win_o6 = win_q[WIN_R2C0];
  assign win_o7 = win_q[WIN_R2C1];
  assign win_o8 = win_q[WIN_R2C2];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 4x4 instance for the small-frame
// scenarios and a 16x16 instance for the random-stall frame.
module tb_sobel_window_ctrl;

  typedef logic [8:0][7:0] win_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_i;
  logic       pixel_valid_i, sof_i, win_ready_i;

  logic pr4, wv4, fd4, pr16, wv16, fd16;
  win_t w4, w16;
`ifdef SOBEL_STALL_CNT_EN
  logic [15:0] sc4, sc16;
`endif

  bit   sel;
  logic pr_s, wv_s, fd_s;
  win_t w_s;

  int tests = 0;
  int fails = 0;

  logic [7:0] img [16][16];
  win_t       got_q [$];
  int         fd_cnt;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
    .sof_i(sof_i), .pixel_ready_o(pr4),
    .win_o0(w4[0]), .win_o1(w4[1]), .win_o2(w4[2]), .win_o3(w4[3]), .win_o4(w4[4]),
    .win_o5(w4[5]), .win_o6(w4[6]), .win_o7(w4[7]), .win_o8(w4[8]),
    .win_valid_o(wv4), .win_ready_i(win_ready_i),
`ifdef SOBEL_STALL_CNT_EN
    .stall_cnt_o(sc4),
`endif
    .frame_done_o(fd4)
  );

  sobel_window_ctrl #(.IMG_WIDTH(16), .IMG_HEIGHT(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
    .sof_i(sof_i), .pixel_ready_o(pr16),
    .win_o0(w16[0]), .win_o1(w16[1]), .win_o2(w16[2]), .win_o3(w16[3]), .win_o4(w16[4]),
    .win_o5(w16[5]), .win_o6(w16[6]), .win_o7(w16[7]), .win_o8(w16[8]),
    .win_valid_o(wv16), .win_ready_i(win_ready_i),
`ifdef SOBEL_STALL_CNT_EN
    .stall_cnt_o(sc16),
`endif
    .frame_done_o(fd16)
  );

  assign pr_s = sel ? pr16 : pr4;
  assign wv_s = sel ? wv16 : wv4;
  assign fd_s = sel ? fd16 : fd4;
  assign w_s  = sel ? w16  : w4;

  // Inputs change just after posedge, so the negedge view predicts the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (wv_s && win_ready_i) got_q.push_back(w_s);
      if (fd_s) fd_cnt++;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pixel_valid_i = 1'b0; sof_i = 1'b0; win_ready_i = 1'b1; pixel_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic send(input logic [7:0] p, input logic sof, input bit rnd);
    int  n = 0;
    bit  done = 0;
    pixel_i = p; sof_i = sof; pixel_valid_i = 1'b1;
    while (!done) begin
      if (rnd) win_ready_i = 1'($urandom_range(0, 1));
      #1 done = pr_s;
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin
        tests++; fails++;
        $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", p, n);
        done = 1;
      end
    end
    pixel_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic send_rows(input int w, input int r0, input int c0, input int r1, input int c1, input bit rnd);
    for (int i = r0*w + c0; i <= r1*w + c1; i++) send(img[i/w][i%w], i == 0, rnd);
  endtask

  task automatic flush();
    pixel_valid_i = 1'b0; win_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input int base, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img[r][c] = 8'(base + 16*r + c);
  endtask

  task automatic check_frame(input string name, input int w, input int h);
    int   idx = 0;
    win_t e;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        for (int k = 0; k < 9; k++) e[k] = img[r-2+k/3][c-2+k%3];
        tests++;
        if (idx >= got_q.size()) begin
          fails++;
          $display("FAIL %s_win(%0d,%0d): missing, required %h", name, r, c, e);
        end else if (got_q[idx] !== e) begin
          fails++;
          $display("FAIL %s_win(%0d,%0d): got %h required %h", name, r, c, got_q[idx], e);
        end
        idx++;
      end
    end
    tests++;
    if (got_q.size() !== (w-2)*(h-2)) begin
      fails++;
      $display("FAIL %s_count: got %0d windows required %0d", name, got_q.size(), (w-2)*(h-2));
    end
    tests++;
    if (fd_cnt !== 1) begin
      fails++;
      $display("FAIL %s_frame_done: got %0d pulses required 1", name, fd_cnt);
    end
  endtask

  function automatic win_t first_win4();
    win_t e;
    e[0] = 8'd0;  e[1] = 8'd1;  e[2] = 8'd2;
    e[3] = 8'd16; e[4] = 8'd17; e[5] = 8'd18;
    e[6] = 8'd32; e[7] = 8'd33; e[8] = 8'd34;
    return e;
  endfunction

  task automatic test_reset();
    sel = 0;
    rst = 1'b1; pixel_valid_i = 1'b0; sof_i = 1'b0; win_ready_i = 1'b0; pixel_i = '0;
    @(posedge clk); #1;
    tests++; if (wv4 !== 1'b0)  begin fails++; $display("FAIL reset_win_valid: got %b required 0", wv4); end
    tests++; if (fd4 !== 1'b0)  begin fails++; $display("FAIL reset_frame_done: got %b required 0", fd4); end
    tests++; if (pr4 !== 1'b1)  begin fails++; $display("FAIL reset_ready: got %b required 1", pr4); end
    tests++; if (w4 !== '0)     begin fails++; $display("FAIL reset_win: got %h required 0", w4); end
    tests++; if (wv16 !== 1'b0) begin fails++; $display("FAIL reset_win_valid16: got %b required 0", wv16); end
`ifdef SOBEL_STALL_CNT_EN
    tests++; if (sc4 !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d required 0", sc4); end
`endif
    do_reset();
  endtask

  task automatic test_basic();
    sel = 0;
    do_reset();
    fill_img(0, 4, 4);
    send_rows(4, 0, 0, 2, 2, 0);
    tests++; if (wv_s !== 1'b1) begin fails++; $display("FAIL basic_first_valid: got %b required 1", wv_s); end
    tests++; if (w_s !== first_win4()) begin fails++; $display("FAIL basic_first_win: got %h required %h", w_s, first_win4()); end
    send_rows(4, 2, 3, 3, 3, 0);
    tests++; if (fd_s !== 1'b1) begin fails++; $display("FAIL basic_frame_done: got %b required 1", fd_s); end
    tests++; if (wv_s !== 1'b1 || w_s[8] !== 8'd51) begin
      fails++; $display("FAIL basic_last_win: valid %b pix %0d required 1/51", wv_s, w_s[8]);
    end
    flush();
    tests++; if (fd_s !== 1'b0) begin fails++; $display("FAIL basic_frame_done_pulse: got %b required 0", fd_s); end
    check_frame("basic", 4, 4);
  endtask

  task automatic test_stall();
    sel = 0;
    do_reset();
    fill_img(0, 4, 4);
    send_rows(4, 0, 0, 2, 2, 0);
    win_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (pr_s !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b required 0", pr_s); end
    tests++; if (wv_s !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b required 1", wv_s); end
    tests++; if (w_s !== first_win4()) begin fails++; $display("FAIL stall_win_hold: got %h required %h", w_s, first_win4()); end
`ifdef SOBEL_STALL_CNT_EN
    tests++; if (sc4 !== 16'd5) begin fails++; $display("FAIL stall_cnt: got %0d required 5", sc4); end
`endif
    win_ready_i = 1'b1;
    send_rows(4, 2, 3, 3, 3, 0);
    flush();
    check_frame("stall", 4, 4);
  endtask

  task automatic test_restart();
    sel = 0;
    do_reset();
    fill_img(0, 4, 4);
    send_rows(4, 0, 0, 2, 0, 0);
    fill_img(100, 4, 4);
    send(img[0][0], 1'b1, 0);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL restart_early_win: got %0d windows required 0", got_q.size()); end
    send_rows(4, 0, 1, 3, 3, 0);
    flush();
    check_frame("restart", 4, 4);
  endtask

  task automatic test_no_sof();
    sel = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tests++;
      #1 if (pr_s !== 1'b1) begin fails++; $display("FAIL nosof_ready[%0d]: got %b required 1", i, pr_s); end
      send(8'(7*i + 3), 1'b0, 0);
    end
    flush();
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL nosof_windows: got %0d required 0", got_q.size()); end
    tests++; if (fd_cnt !== 0) begin fails++; $display("FAIL nosof_frame_done: got %0d required 0", fd_cnt); end
    tests++; if (wv_s !== 1'b0) begin fails++; $display("FAIL nosof_valid: got %b required 0", wv_s); end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    fill_img(0, 4, 4);
    send_rows(4, 0, 0, 2, 2, 0);
    tests++; if (wv_s !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %b required 1", wv_s); end
    rst = 1'b1;
    #1;
    tests++; if (wv_s !== 1'b0) begin fails++; $display("FAIL rstmid_valid_drop: got %b required 0", wv_s); end
    tests++; if (pr_s !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b required 1", pr_s); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    fill_img(50, 4, 4);
    send_rows(4, 0, 0, 3, 3, 0);
    flush();
    check_frame("rstmid", 4, 4);
  endtask

  task automatic test_random();
    sel = 1;
    do_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom_range(0, 255));
    send_rows(16, 0, 0, 15, 15, 1);
    flush();
    check_frame("random", 16, 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_no_sof();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 16, pixels per line (min 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 16, lines per frame (min 3).
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pixel_i  input  PIXEL_WIDTH_OUT  grayscale input pixel.
REQ-006 SHALL have port pixel_valid_i  input  1  input beat valid.
REQ-007 SHALL have port sof_i  input  1  beat is first pixel of frame; qualified by pixel_valid_i.
REQ-008 SHALL have port pixel_ready_o  output  1  input beat accepted when valid and ready.
REQ-009 SHALL have ports win_o0..win_o8  output  PIXEL_WIDTH_OUT each  3x3 window, row-major, feeding sobel_core.
REQ-010 SHALL have port win_valid_o  output  1  window valid.
REQ-011 SHALL have port win_ready_i  input  1  downstream accepts window.
REQ-012 SHALL have port frame_done_o  output  1  one-cycle pulse, last frame pixel accepted.

Function
REQ-013 SHALL implement FSM IDLE -> ACTIVE on accepted beat with sof_i=1; ACTIVE -> IDLE on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-014 SHALL in IDLE accept and discard beats with sof_i=0 (pixel_ready_o=1, no window, no buffer write).
REQ-015 SHALL keep col/row counters; an accepted sof beat is pixel (0,0) in any state (mid-frame restart discards partial frame); col wraps IMG_WIDTH-1 -> 0 with row+1.
REQ-016 SHALL keep two line buffers of IMG_WIDTH entries (row-2, row-1) indexed by col, plus 3x3 shift window; per accepted pixel, each buffer read and written at same col in the same cycle.
REQ-017 SHALL map window: win_o0..2 = row-2 cols c-2..c; win_o3..5 = row-1; win_o6..8 = current row, win_o8 = accepted pixel.
REQ-018 SHALL raise win_valid_o exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2; no windows straddle line wrap; (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-019 SHALL hold win_o* and win_valid_o stable while win_valid_o=1 and win_ready_i=0.
REQ-020 SHALL drive pixel_ready_o = !win_valid_o || win_ready_i (single output register, no bubbles at full throughput).
REQ-021 SHALL clear win_valid_o after handshake when no new window is produced that cycle; simultaneous handshake plus new window loads the new window.
REQ-022 SHALL assert frame_done_o the cycle after the last pixel is accepted, concurrent with the last win_valid_o.
REQ-023 SHALL use unsigned pixel values only; no arithmetic beyond counters.

Reset
REQ-024 SHALL on rst_i=1: state IDLE, counters 0, win_valid_o=0, frame_done_o=0, win_o*=0, pixel_ready_o=1 (combinational from cleared win_valid_o).
REQ-025 SHALL not require line-buffer contents to be reset; stale contents never reach a valid window.
REQ-026 SHALL, on reset mid-frame, drop the pending window and wait for a new sof.

Configuration
REQ-027 SHALL, with SOBEL_STALL_CNT_EN defined, add output stall_cnt_o (16 bits), reset 0, incremented each cycle win_valid_o=1 and win_ready_i=0, saturating at 16'hFFFF, cleared on accepted sof.
REQ-028 SHALL, without SOBEL_STALL_CNT_EN, omit stall_cnt_o and its logic entirely.

Structure
REQ-029 SHALL take PIXEL_WIDTH_OUT from the shared parameters header; FSM state enum and a win_idx constant set belong in that package.
REQ-030 SHALL instantiate one sub-module, sobel_line_buffer (single-port read-before-write, depth IMG_WIDTH), twice.

Verification
REQ-031 SHALL check: 4x4 frame, pixel = 16*r+c, win_ready_i=1 -> 4 windows; first win_o0..8 = 0,1,2,16,17,18,32,33,34 one cycle after pixel (2,2).
REQ-032 SHALL check: win_ready_i=0 for 5 cycles with window pending -> pixel_ready_o=0, win_o* unchanged, stall_cnt_o=5 (macro on).
REQ-033 SHALL check: sof re-asserted at pixel (2,1) of 4x4 frame -> no window until new (2,2); total windows then 4.
REQ-034 SHALL check: beats with sof_i=0 after reset -> all accepted, win_valid_o stays 0, frame_done_o 0.
REQ-035 SHALL check: rst_i pulse while win_valid_o=1 -> win_valid_o=0 immediately, next frame produces correct windows.
REQ-036 SHALL check: 16x16 random frame, random win_ready_i -> 196 windows matching golden model, one frame_done_o pulse.
